// File: rtl/wrapping_updown_counter_if.sv
// rtl/wrapping_updown_counter_if.sv - step request / count bundle for wrapping_updown_counter
interface wrapping_updown_counter_if #(
    parameter int RANGE = 4
);
    localparam int WIDTH = $clog2(RANGE);

    logic             increment;
    logic             decrement;
    logic [WIDTH-1:0] count;

    modport master (
        output increment,
        output decrement,
        input  count
    );

    modport slave (
        input  increment,
        input  decrement,
        output count
    );
endinterface

// File: rtl/wrapping_updown_counter.sv
// rtl/wrapping_updown_counter.sv - modulo-RANGE up/down counter with registered output
module wrapping_updown_counter #(
    parameter int RANGE       = 4,
    parameter int RESET_VALUE = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    wrapping_updown_counter_if.slave    bus
);
    localparam int WIDTH = $clog2(RANGE);
    localparam logic [WIDTH-1:0] MAX_CODE   = WIDTH'(RANGE - 1);
    localparam logic [WIDTH-1:0] RESET_CODE = WIDTH'(RESET_VALUE);

    generate
        if (RANGE < 2) begin : g_bad_range
            $fatal(1, "wrapping_updown_counter: RANGE must be >= 2");
        end
        if (RESET_VALUE < 0 || RESET_VALUE >= RANGE) begin : g_bad_reset_value
            $fatal(1, "wrapping_updown_counter: RESET_VALUE must lie in 0..RANGE-1");
        end
    endgenerate

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;
    logic             w_at_max;
    logic             w_at_min;

    // Explicit end-point compares keep non-power-of-two ranges from reaching unused codes.
    assign w_at_max = (r_count == MAX_CODE);
    assign w_at_min = (r_count == '0);

    always_comb begin
        w_next = r_count;
        case ({bus.increment, bus.decrement})
            2'b10:   w_next = w_at_max ? '0 : r_count + WIDTH'(1);
            2'b01:   w_next = w_at_min ? MAX_CODE : r_count - WIDTH'(1);
            default: w_next = r_count;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= RESET_CODE;
        end else begin
            r_count <= w_next;
        end
    end

    assign bus.count = r_count;
endmodule

// File: tb/tb_wrapping_updown_counter.sv
// tb/tb_wrapping_updown_counter.sv - scoreboard bench for wrapping_updown_counter
module tb_wrapping_updown_counter;
    localparam int RA = 4;
    localparam int VA = 0;
    localparam int RB = 5;
    localparam int VB = 3;

    logic clock = 1'b0;
    logic reset_a;
    logic reset_b;

    always #5 clock = ~clock;

    wrapping_updown_counter_if #(.RANGE(RA)) bus_a ();
    wrapping_updown_counter_if #(.RANGE(RB)) bus_b ();

    wrapping_updown_counter #(.RANGE(RA), .RESET_VALUE(VA)) dut_a (
        .clock (clock),
        .reset (reset_a),
        .bus   (bus_a.slave)
    );

    wrapping_updown_counter #(.RANGE(RB), .RESET_VALUE(VB)) dut_b (
        .clock (clock),
        .reset (reset_b),
        .bus   (bus_b.slave)
    );

    int n_vectors     = 0;
    int n_miscompares = 0;
    int exp_q[$];
    int m_a;
    int m_b;

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vectors++;
        if (observed !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int model_next(input int cur, input bit inc, input bit dec, input int range);
        if (inc && !dec) return (cur == range - 1) ? 0 : cur + 1;
        if (dec && !inc) return (cur == 0) ? range - 1 : cur - 1;
        return cur;
    endfunction

    task automatic pop_check(input string tag, input logic [31:0] observed);
        if (exp_q.size() == 0) begin
            check_value({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            check_value(tag, observed, exp_q.pop_front());
        end
    endtask

    // Drives one cycle on DUT A, predicting the post-edge count.
    task automatic step_a(input bit rst, input bit inc, input bit dec, input string tag);
        reset_a         = rst;
        bus_a.increment = inc;
        bus_a.decrement = dec;
        m_a = rst ? VA : model_next(m_a, inc, dec, RA);
        exp_q.push_back(m_a);
        @(posedge clock);
        #1;
        pop_check(tag, 32'(bus_a.count));
    endtask

    task automatic step_b(input bit rst, input bit inc, input bit dec, input string tag);
        reset_b         = rst;
        bus_b.increment = inc;
        bus_b.decrement = dec;
        m_b = rst ? VB : model_next(m_b, inc, dec, RB);
        exp_q.push_back(m_b);
        @(posedge clock);
        #1;
        pop_check(tag, 32'(bus_b.count));
        check_value({tag, "_in_range"}, 32'(bus_b.count < 3'(RB)), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        bus_a.increment = 1'b0;
        bus_a.decrement = 1'b0;
        bus_b.increment = 1'b0;
        bus_b.decrement = 1'b0;
        m_a = VA;
        m_b = VB;
        @(posedge clock);
        @(posedge clock);
        #1;
        check_value("a_reset", 32'(bus_a.count), VA);
        check_value("b_reset", 32'(bus_b.count), VB);
        reset_b = 1'b0;

        for (int i = 0; i < 10; i++) step_a(1'b0, 1'b0, 1'b0, "a_idle_after_reset");

        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 1'b0, "a_inc");
        for (int i = 0; i < 10; i++) step_a(1'b0, 1'b0, 1'b0, "a_hold_max");
        step_a(1'b0, 1'b1, 1'b0, "a_inc_wrap");
        for (int i = 0; i < 4; i++) step_a(1'b0, 1'b1, 1'b0, "a_inc_lap");

        step_a(1'b0, 1'b0, 1'b1, "a_dec_wrap");
        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b0, 1'b1, "a_dec");
        for (int i = 0; i < 4; i++) step_a(1'b0, 1'b0, 1'b1, "a_dec_lap");

        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 1'b1, "a_both_at0");
        step_a(1'b0, 1'b1, 1'b0, "a_inc_to1");
        step_a(1'b0, 1'b1, 1'b0, "a_inc_to2");
        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 1'b1, "a_both_at2");
        step_a(1'b0, 1'b1, 1'b0, "a_inc_to3");
        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 1'b1, "a_both_at3");
        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b0, 1'b0, "a_none_at3");

        // Reset raised between edges must act before the next edge.
        step_a(1'b0, 1'b0, 1'b1, "a_dec_to2");
        reset_a = 1'b1;
        #2;
        check_value("a_async_reset", 32'(bus_a.count), VA);
        m_a = VA;
        step_a(1'b1, 1'b1, 1'b0, "a_reset_held");
        step_a(1'b0, 1'b0, 1'b0, "a_after_reset");

        step_b(1'b0, 1'b1, 1'b0, "b_inc_to4");
        step_b(1'b0, 1'b1, 1'b0, "b_inc_wrap");
        step_b(1'b0, 1'b0, 1'b1, "b_dec_wrap");
        for (int i = 0; i < 200; i++) begin
            step_b((i == 100), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "b_random");
        end

        for (int i = 0; i < 1000; i++) begin
            step_a((i >= 500 && i < 502), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "a_random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule

// File: doc/wrapping_updown_counter.md
Name: wrapping_updown_counter

Overview:
- Parameterizable modulo-RANGE up/down counter with a single registered output.
- Counts 0..RANGE-1 and wraps in both directions; RANGE need not be a power of two.
- Generic building block for ring pointers, round-robin indices and slot selectors.
- Fully synchronous to one clock, except the asynchronous reset.

Parameters:
- RANGE, default 4: number of distinct count values; count spans 0..RANGE-1; legal RANGE >= 2.
- RESET_VALUE, default 0: value loaded on reset; legal 0..RANGE-1.
- WIDTH, derived (localparam) = $clog2(RANGE): width of count; not overridable.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- decrement  input  1  request to count down by one this cycle.
- increment  input  1  request to count up by one this cycle.
- count  output  WIDTH  current counter value, driven directly from a register.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset:
  - reset=1 forces count=RESET_VALUE immediately, without waiting for a clock edge.
  - count holds RESET_VALUE while reset is high.
  - Reset deassertion is synchronised by the integrator; the first update happens on the first rising clock edge with reset low.
  - Reset mid-operation discards the current count.
- Update on each rising edge with reset=0; next count depends only on the current count and the sampled inputs:
  - increment=1, decrement=0: count = (count==RANGE-1) ? 0 : count+1.
  - decrement=1, increment=0: count = (count==0) ? RANGE-1 : count-1.
  - both 1 or both 0: count holds (simultaneous events cancel).
- Latency: an input sampled at edge N is reflected on count right after edge N; one-cycle registered latency, no combinational path from inputs to count.
- Wrap detection uses explicit comparison against RANGE-1 and 0, never natural binary overflow. Non-power-of-two RANGE (e.g. 5, 3 bits) therefore never produces codes >= RANGE.
- Count never leaves 0..RANGE-1 once out of reset.
- No handshake or backpressure: every enabled edge updates.
- Elaboration-time checks: RANGE < 2 or RESET_VALUE outside 0..RANGE-1 triggers a fatal error.

Test Plan:
1. Reset value: RANGE=4, RESET_VALUE=0; assert reset, release, idle 10 cycles -> count=0 throughout. Asserting reset between clock edges forces count=RESET_VALUE before the next edge.
2. Increment and wrap:
   - Hold increment=1 from 0 -> count 1,2,3 on successive edges.
   - Idle 10 cycles -> holds 3.
   - One more increment -> 0.
   - Four consecutive increments from 0 -> 1,2,3,0.
3. Decrement and wrap:
   - From 0, one decrement -> 3.
   - Hold decrement=1 -> 2,1,0.
   - Four consecutive decrements from 0 -> 3,2,1,0.
4. Simultaneous and idle: increment=decrement=1 for several edges at counts 0, 2 and 3 -> count unchanged. Both 0 -> unchanged.
5. Non-power-of-two: RANGE=5, RESET_VALUE=3:
   - After reset count=3.
   - Increments -> 4,0.
   - Decrement from 0 -> 4.
   - Count never shows 5, 6 or 7.
6. Random: 1000 cycles, increment and decrement each drawn with p=0.5, reset applied mid-run. A reference model (wrap rules above, hold on both/none, reset to RESET_VALUE) matches count after every edge.
